// File: rtl/dac_spi_driver_pkg.sv
// Shared constants and types for the vector display DAC path.
// Holds sample width, DAC frame layout and the driver FSM states.
package vector_pkg;

    localparam int OUT_WIDTH  = 8;
    localparam int DAC_BITS   = 12;
    localparam int FRAME_BITS = 16;

    // {ch, 0, GA_n, SHDN_n}: channel A/B, 1x gain, output active
    localparam logic [3:0] PFX_A = 4'b0011;
    localparam logic [3:0] PFX_B = 4'b1011;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_A,
        GAP,
        SHIFT_B,
        LATCH
    } dac_state_e;

    function automatic logic [FRAME_BITS-1:0] make_frame(
        input logic [3:0]          pfx,
        input logic [DAC_BITS-1:0] code
    );
        return {pfx, code};
    endfunction

endpackage

// File: rtl/dac_spi_driver_if.sv
// Sample handshake between the game core and the DAC driver.
// The core is the master; the driver is the slave.
interface dac_spi_driver_if #(
    parameter int OUT_WIDTH = vector_pkg::OUT_WIDTH
) ();

    logic                 sample_valid;
    logic                 sample_ready;
    logic [OUT_WIDTH-1:0] xin;
    logic [OUT_WIDTH-1:0] yin;

    modport master (
        output sample_valid,
        output xin,
        output yin,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  xin,
        input  yin,
        output sample_ready
    );

endinterface

// File: rtl/dac_spi_driver_frame_tx.sv
// Shifts one 16-bit SPI word out MSB first, SCLK idle low.
// done is high in the last cycle of bit 0, before SCLK falls.
module spi_frame_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] word,
    output logic        sclk,
    output logic        mosi,
    output logic        done
);

    import vector_pkg::*;

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic          busy_q, busy_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic [14:0]   rest_q, rest_d;
    logic [3:0]    bit_q,  bit_d;
    logic [DW-1:0] div_q,  div_d;
    logic          half_end;

    assign half_end = (div_q == DIV_LAST);

    // Half-period timing, bit counting and data shifting
    always_comb begin
        busy_d = busy_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        rest_d = rest_q;
        bit_d  = bit_q;
        div_d  = div_q;
        done   = 1'b0;
        if (start) begin
            busy_d = 1'b1;
            sclk_d = 1'b0;
            mosi_d = word[FRAME_BITS-1];
            rest_d = word[14:0];
            bit_d  = 4'd15;
            div_d  = '0;
        end else if (busy_q) begin
            div_d = div_q + 1'b1;
            if (half_end) begin
                div_d = '0;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    sclk_d = 1'b0;
                    if (bit_q == 4'd0) begin
                        busy_d = 1'b0;
                        mosi_d = 1'b0;
                        done   = 1'b1;
                    end else begin
                        bit_d  = bit_q - 1'b1;
                        mosi_d = rest_q[14];
                        rest_d = {rest_q[13:0], 1'b0};
                    end
                end
            end
        end
    end

    // Shifter state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            rest_q <= '0;
            bit_q  <= '0;
            div_q  <= '0;
        end else begin
            busy_q <= busy_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
            rest_q <= rest_d;
            bit_q  <= bit_d;
            div_q  <= div_d;
        end
    end

    assign sclk = sclk_q;
    assign mosi = mosi_q;

endmodule

// File: rtl/dac_spi_driver.sv
// Dual-channel SPI DAC driver: X to channel A, Y to channel B,
// then an LDAC strobe so both deflection channels move together.
module dac_spi_driver #(
    parameter int OUT_WIDTH = vector_pkg::OUT_WIDTH,
    parameter int CLK_DIV   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    dac_spi_driver_if.slave    smp,
    output logic               dac_cs_n,
    output logic               dac_sclk,
    output logic               dac_mosi,
    output logic               dac_ldac_n
);

    import vector_pkg::*;

    if (OUT_WIDTH < 1 || OUT_WIDTH > DAC_BITS || CLK_DIV < 1) begin : g_bad_cfg
        $error("dac_spi_driver: need 1<=OUT_WIDTH<=12 and CLK_DIV>=1");
    end

    localparam int GW = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(2 * CLK_DIV - 1);

    dac_state_e           state_q,  state_d;
    logic [GW-1:0]        cnt_q,    cnt_d;
    logic [OUT_WIDTH-1:0] y_q,      y_d;
    logic                 cs_n_q,   cs_n_d;
    logic                 ldac_n_q, ldac_n_d;
    logic                 ready_q,  ready_d;

    logic                  accept;
    logic                  tx_start;
    logic [FRAME_BITS-1:0] tx_word;
    logic                  tx_done;
    logic [DAC_BITS-1:0]   code_x;
    logic [DAC_BITS-1:0]   code_y;

    // Samples are left-aligned so the top bits drive the full DAC span
    assign code_x = DAC_BITS'(smp.xin) << (DAC_BITS - OUT_WIDTH);
    assign code_y = DAC_BITS'(y_q) << (DAC_BITS - OUT_WIDTH);
    assign accept = (state_q == IDLE) && ready_q && smp.sample_valid;

    // Frame sequencing: A, gap, B, latch strobe, back to idle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        cs_n_d   = cs_n_q;
        ldac_n_d = ldac_n_q;
        ready_d  = ready_q;
        tx_start = 1'b0;
        tx_word  = make_frame(PFX_A, code_x);
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    y_d      = smp.yin;
                    tx_start = 1'b1;
                    tx_word  = make_frame(PFX_A, code_x);
                    cs_n_d   = 1'b0;
                    ready_d  = 1'b0;
                    state_d  = SHIFT_A;
                end
            end
            SHIFT_A: begin
                if (tx_done) begin
                    cs_n_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP_LAST) begin
                    tx_start = 1'b1;
                    tx_word  = make_frame(PFX_B, code_y);
                    cs_n_d   = 1'b0;
                    state_d  = SHIFT_B;
                end
            end
            SHIFT_B: begin
                if (tx_done) begin
                    cs_n_d   = 1'b1;
                    ldac_n_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = LATCH;
                end
            end
            LATCH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP_LAST) begin
                    ldac_n_d = 1'b1;
                    ready_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and output registers; reset drops any transfer in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            y_q      <= '0;
            cs_n_q   <= 1'b1;
            ldac_n_q <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            cs_n_q   <= cs_n_d;
            ldac_n_q <= ldac_n_d;
            ready_q  <= ready_d;
        end
    end

    spi_frame_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (tx_start),
        .word  (tx_word),
        .sclk  (dac_sclk),
        .mosi  (dac_mosi),
        .done  (tx_done)
    );

    assign smp.sample_ready = ready_q;
    assign dac_cs_n         = cs_n_q;
    assign dac_ldac_n       = ldac_n_q;

endmodule
